clk_gen_glitch_free_mux: RTL and testbench

- Clock-generation and clock-selection block.
- Derives four clocks from sys_clk by integer division, standing in for the PLL_4 function, and produces a lock indicator.
- Drives clk_out from one of three derived clocks through a glitch-free switching mux, selected by a 2-bit mode.
- Sits at the clock root of the signal-processing datapath; downstream logic runs on clk_out.

---
 rtl/clk_gen_glitch_free_mux_pkg.sv | 21 ++
 rtl/clk_gen_glitch_free_mux_clk_div_even.sv | 42 ++++
 rtl/clk_gen_glitch_free_mux.sv | 103 ++++++++++
 tb/tb_clk_gen_glitch_free_mux.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_glitch_free_mux_pkg.sv
// Shared constants for the clock generator / glitch-free clock mux slice.
`timescale 1ns/100ps
package clk_gen_glitch_free_mux_pkg;

   // sel encoding (sys_clk domain); value i selects mux source i
   localparam logic [1:0] SEL_CLK1 = 2'd0;
   localparam logic [1:0] SEL_CLK2 = 2'd1;
   localparam logic [1:0] SEL_CLK3 = 2'd2;
   localparam logic [1:0] SEL_OFF  = 2'd3;

   // Default divide ratios against the 200 MHz reference
   localparam int DIV0_DEF        = 200;
   localparam int DIV1_DEF        = 8;
   localparam int DIV2_DEF        = 4;
   localparam int DIV3_DEF        = 2;
   localparam int LOCK_CYCLES_DEF = 16;

   // Number of clocks feeding the switching mux (clk_div1..clk_div3)
   localparam int NUM_SRC = 3;

endpackage

// File: rtl/clk_gen_glitch_free_mux_clk_div_even.sv
// Even integer clock divider: counter plus registered toggle flop, 50% duty.
// DIV must be even and >= 2; the output is a flop, so it never glitches.
`timescale 1ns/100ps
module clk_div_even #(
   parameter int DIV = 2
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   output logic clk_div
);

   localparam int HALF = DIV / 2;
   localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(HALF - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_q, clk_d;

   // Count half periods; toggle and wrap at the terminal count
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      clk_d = clk_q;
      if (cnt_q == CNT_MAX) begin
         cnt_d = '0;
         clk_d = ~clk_q;
      end
   end

   // Counter and toggle flop, cleared asynchronously
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q <= '0;
         clk_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         clk_q <= clk_d;
      end
   end

   assign clk_div = clk_q;

endmodule

// File: rtl/clk_gen_glitch_free_mux.sv
// Clock root: four divided clocks, a lock indicator, and a glitch-free mux
// that switches clk_out between clk_div1..3 with a break-before-make
// handshake. Each source's enable is synchronized on that source's falling
// edge, so the AND gate only opens or closes while the source is low.
`timescale 1ns/100ps
module clk_gen_glitch_free_mux
   import clk_gen_glitch_free_mux_pkg::*;
#(
   parameter int DIV0        = DIV0_DEF,
   parameter int DIV1        = DIV1_DEF,
   parameter int DIV2        = DIV2_DEF,
   parameter int DIV3        = DIV3_DEF,
   parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic [1:0] sel,
   output logic       clk_div0,
   output logic       clk_div1,
   output logic       clk_div2,
   output logic       clk_div3,
   output logic       pll_lock,
   output logic       clk_out
);

   localparam int LW = $clog2(LOCK_CYCLES + 1);
   localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CYCLES);

   clk_div_even #(.DIV(DIV0)) u_div0 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_div(clk_div0));
   clk_div_even #(.DIV(DIV1)) u_div1 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_div(clk_div1));
   clk_div_even #(.DIV(DIV2)) u_div2 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_div(clk_div2));
   clk_div_even #(.DIV(DIV3)) u_div3 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clk_div(clk_div3));

   logic [LW-1:0] lock_cnt_q, lock_cnt_d;
   logic          pll_lock_q, pll_lock_d;

   // Saturating lock counter; lock is sticky until reset
   always_comb begin
      lock_cnt_d = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LW'(1);
      pll_lock_d = pll_lock_q | (lock_cnt_d == LOCK_MAX);
   end

   // Lock counter and lock flag
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lock_cnt_q <= '0;
         pll_lock_q <= 1'b0;
      end else begin
         lock_cnt_q <= lock_cnt_d;
         pll_lock_q <= pll_lock_d;
      end
   end

   assign pll_lock = pll_lock_q;

   logic                mux_rst_n;
   logic [NUM_SRC-1:0]  src, en;

   assign mux_rst_n = sys_rst_n & pll_lock_q;
   assign src       = {clk_div3, clk_div2, clk_div1};

   genvar i;
   generate
      for (i = 0; i < NUM_SRC; i++) begin : g_src
         logic rst_meta_q, rst_sync_q;
         logic req_d, req_q;
         logic en_d, en_q;

         // Reset assert is immediate; release is retimed to this source's falling edge
         always_ff @(negedge src[i] or negedge mux_rst_n) begin
            if (!mux_rst_n) begin
               rst_meta_q <= 1'b0;
               rst_sync_q <= 1'b0;
            end else begin
               rst_meta_q <= 1'b1;
               rst_sync_q <= rst_meta_q;
            end
         end

         // Request only when selected and every other source has let go
         always_comb begin
            req_d = (sel == 2'(i)) && ((en & ~(NUM_SRC'(1) << i)) == '0);
            en_d  = req_q;
         end

         // Two-stage enable chain on the falling edge of this source
         always_ff @(negedge src[i] or negedge rst_sync_q) begin
            if (!rst_sync_q) begin
               req_q <= 1'b0;
               en_q  <= 1'b0;
            end else begin
               req_q <= req_d;
               en_q  <= en_d;
            end
         end

         assign en[i] = en_q;
      end
   endgenerate

   assign clk_out = |(src & en);

endmodule

// File: tb/tb_clk_gen_glitch_free_mux.sv
// Directed bench for clk_gen_glitch_free_mux: reset/lock timing, divider
// periods, source stepping, fast-to-slow switching, rapid reselection and
// mid-operation reset, plus continuous pulse-width and one-hot monitors.
`timescale 1ns/100ps
module tb_clk_gen_glitch_free_mux;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic [1:0] sel       = 2'd0;
   logic       clk_div0, clk_div1, clk_div2, clk_div3, pll_lock, clk_out;

   int n_checks = 0;
   int n_fails  = 0;

   clk_gen_glitch_free_mux dut (
      .sys_clk  (sys_clk),
      .sys_rst_n(sys_rst_n),
      .sel      (sel),
      .clk_div0 (clk_div0),
      .clk_div1 (clk_div1),
      .clk_div2 (clk_div2),
      .clk_div3 (clk_div3),
      .pll_lock (pll_lock),
      .clk_out  (clk_out)
   );

   always #2.5 sys_clk = ~sys_clk;

   logic [4:0] obs;
   assign obs = {clk_out, clk_div3, clk_div2, clk_div1, clk_div0};

   // Pulse-width monitor: every clk_out phase must be at least 5 ns
   bit      mon_en    = 1'b0;
   int      glitch_cnt = 0;
   realtime last_t    = 0.0;
   always @(clk_out) begin
      if (mon_en && (($realtime - last_t) < 4.9)) begin
         glitch_cnt++;
         $display("FAIL clk_out_pulse: width %0.1f ns at %0t, required >= 5 ns", $realtime - last_t, $time);
      end
      last_t = $realtime;
   end

   // At most one mux enable high at any time
   int onehot_err = 0;
   always @(negedge sys_clk) begin
      if ($countones(dut.en) > 1) onehot_err++;
   end

   // Measure one high run and the following low run of obs[idx] in sys_clk cycles
   task automatic measure(input int idx, output int hi, output int lo);
      logic prev;
      bit   found;
      hi = -1; lo = -1; found = 1'b0;
      @(negedge sys_clk); prev = obs[idx];
      for (int k = 0; k < 2000; k++) begin
         @(negedge sys_clk);
         if (!prev && obs[idx]) begin found = 1'b1; break; end
         prev = obs[idx];
      end
      if (!found) return;
      hi = 0;
      while (obs[idx] && hi < 2000) begin hi++; @(negedge sys_clk); end
      lo = 0;
      while (!obs[idx] && lo < 2000) begin lo++; @(negedge sys_clk); end
   endtask

   task automatic test_reset();
      logic [5:0] got;
      #100;
      got = {clk_div0, clk_div1, clk_div2, clk_div3, pll_lock, clk_out};
      n_checks++;
      if (got !== 6'b0) begin
         n_fails++;
         $display("FAIL reset_outputs: got %b want 000000", got);
      end
      sys_rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(posedge sys_clk); #1;
         n_checks++;
         if (pll_lock !== (k == 16)) begin
            n_fails++;
            $display("FAIL lock_timing: cycle %0d pll_lock=%b want %b", k, pll_lock, (k == 16));
         end
         if (k == 1) begin
            n_checks++;
            if ({clk_div3, clk_div2} !== 2'b10) begin
               n_fails++;
               $display("FAIL first_edge_c1: div3/div2=%b%b want 10", clk_div3, clk_div2);
            end
         end
         if (k == 2 || k == 3) begin
            n_checks++;
            if ({clk_div2, clk_div1} !== 2'b10) begin
               n_fails++;
               $display("FAIL first_edge_c%0d: div2/div1=%b%b want 10", k, clk_div2, clk_div1);
            end
         end
         if (k == 4) begin
            n_checks++;
            if (clk_div1 !== 1'b1) begin
               n_fails++;
               $display("FAIL first_edge_c4: div1=%b want 1", clk_div1);
            end
         end
      end
   endtask

   task automatic test_div_periods();
      int want[4] = '{100, 4, 2, 1};
      int hi, lo;
      for (int d = 0; d < 4; d++) begin
         measure(d, hi, lo);
         n_checks++;
         if (hi !== want[d] || lo !== want[d]) begin
            n_fails++;
            $display("FAIL div%0d_period: high %0d low %0d cycles, want %0d/%0d", d, hi, lo, want[d], want[d]);
         end
      end
   endtask

   task automatic test_sel_step();
      int want[3] = '{4, 2, 1};
      int hi, lo, highs;
      for (int s = 0; s < 3; s++) begin
         sel = 2'(s);
         repeat (256) @(negedge sys_clk);
         measure(4, hi, lo);
         n_checks++;
         if (hi !== want[s] || lo !== want[s]) begin
            n_fails++;
            $display("FAIL sel%0d_clk_out: high %0d low %0d cycles, want %0d/%0d", s, hi, lo, want[s], want[s]);
         end
      end
      sel = 2'd3;
      repeat (256) @(negedge sys_clk);
      highs = 0;
      repeat (64) begin @(negedge sys_clk); if (clk_out) highs++; end
      n_checks++;
      if (highs !== 0) begin
         n_fails++;
         $display("FAIL sel3_parked: clk_out high for %0d samples, want 0", highs);
      end
   endtask

   task automatic test_fast_to_slow();
      int lows, hi, lo;
      bit gap;
      sel = 2'd2;
      repeat (256) @(negedge sys_clk);
      sel = 2'd0;
      lows = 0; gap = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge sys_clk);
         lows = clk_out ? 0 : lows + 1;
         if (lows >= 3) begin gap = 1'b1; break; end
      end
      n_checks++;
      if (!gap) begin
         n_fails++;
         $display("FAIL f2s_gap: no low gap seen, want >= 3 low cycles");
      end
      measure(4, hi, lo);
      n_checks++;
      if (hi !== 4 || lo !== 4) begin
         n_fails++;
         $display("FAIL f2s_first_pulse: high %0d low %0d cycles, want 4/4", hi, lo);
      end
   endtask

   task automatic test_quick_toggle();
      int hi, lo;
      repeat (64) @(negedge sys_clk);
      sel = 2'd1;
      @(negedge sys_clk);
      sel = 2'd0;
      repeat (256) @(negedge sys_clk);
      measure(4, hi, lo);
      n_checks++;
      if (hi !== 4 || lo !== 4) begin
         n_fails++;
         $display("FAIL toggle_settle: high %0d low %0d cycles, want 4/4", hi, lo);
      end
   endtask

   task automatic test_reset_mid();
      int  hi, lo, highs;
      bit  seen;
      logic [5:0] got;
      seen = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge sys_clk);
         if (clk_out) begin seen = 1'b1; break; end
      end
      n_checks++;
      if (!seen) begin
         n_fails++;
         $display("FAIL rst_mid_pre: clk_out not toggling, got 0 want 1");
      end
      mon_en = 1'b0;
      #1;
      sys_rst_n = 1'b0;
      #0.5;
      got = {clk_div0, clk_div1, clk_div2, clk_div3, pll_lock, clk_out};
      n_checks++;
      if (got !== 6'b0) begin
         n_fails++;
         $display("FAIL rst_mid_outputs: got %b want 000000", got);
      end
      repeat (4) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      highs = 0;
      for (int k = 1; k <= 16; k++) begin
         @(posedge sys_clk); #1;
         if (clk_out) highs++;
         n_checks++;
         if (pll_lock !== (k == 16)) begin
            n_fails++;
            $display("FAIL rst_mid_lock: cycle %0d pll_lock=%b want %b", k, pll_lock, (k == 16));
         end
      end
      n_checks++;
      if (highs !== 0) begin
         n_fails++;
         $display("FAIL rst_mid_hold: clk_out high %0d samples before lock, want 0", highs);
      end
      repeat (256) @(negedge sys_clk);
      measure(4, hi, lo);
      n_checks++;
      if (hi !== 4 || lo !== 4) begin
         n_fails++;
         $display("FAIL rst_mid_resume: high %0d low %0d cycles, want 4/4", hi, lo);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_monitors();
      repeat (64) @(negedge sys_clk);
      n_checks++;
      if (glitch_cnt !== 0) begin
         n_fails++;
         $display("FAIL pulse_width: %0d short pulses, want 0", glitch_cnt);
      end
      n_checks++;
      if (onehot_err !== 0) begin
         n_fails++;
         $display("FAIL enable_onehot: %0d multi-enable samples, want 0", onehot_err);
      end
   endtask

   initial begin
      test_reset();
      mon_en = 1'b1;
      test_div_periods();
      test_sel_step();
      test_fast_to_slow();
      test_quick_toggle();
      test_reset_mid();
      test_monitors();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
